// File: rtl/jtkcpu_useq.sv
// Microcode sequencer for the JTKCPU family: ROM address generation,
// call/return stack, dispatch and edge/level interrupt arbitration.
//
// Ports: clk, rst (async, active high), cen (clock enable), busy (stall)
//   ni/jmp/call/ret + jmp_addr : ucode flow-control bits and target
//   cat, bad_cat               : category of the fetched opcode
//   int_rq, int_mask           : interrupt requests / per-channel blocks
//   addr                       : current ucode ROM address
//   int_vec                    : one-hot channel being serviced
//   int_srv                    : combinational, any unmasked pending channel
//   err                        : sticky fault flag, parks the sequencer
module jtkcpu_useq #(
  parameter int AW = 10,
  parameter int CATW = 6,
  parameter int NINT = 3,
  parameter logic [NINT-1:0] EDGE_MASK = 3'b100,
  parameter int SDEPTH = 4,
  parameter int RST_CAT = 0,
  parameter int INT_CAT0 = 1
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            busy,
  input  logic            ni,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [AW-1:0]   jmp_addr,
  input  logic [CATW-1:0] cat,
  input  logic            bad_cat,
  input  logic [NINT-1:0] int_rq,
  input  logic [NINT-1:0] int_mask,
  output logic [AW-1:0]   addr,
  output logic [NINT-1:0] int_vec,
  output logic            int_srv,
  output logic            err
);

  localparam int LW  = AW - CATW;
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int IW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  typedef enum logic [1:0] {
    RUN, FETCH, DISPATCH, HALT
  } state_t;

  state_t          st;
  logic [SPW-1:0]  sp;
  logic [IW-1:0]   pop_i;
  logic [AW-1:0]   stk [SDEPTH];
  logic [NINT-1:0] pend_q, rq_prev;
  logic [NINT-1:0] pend, avail, sel_oh, pend_nx;
  logic [CATW-1:0] sel_cat;
  logic            full, empty, fault, push;

  function automatic logic [AW-1:0] entry(
    input logic [CATW-1:0] c
  );
    return {c, {LW{1'b0}}};
  endfunction

  always_comb begin
    // level channels bypass the latch entirely
    pend    = (pend_q & EDGE_MASK)
            | (int_rq & ~EDGE_MASK);
    avail   = pend & ~int_mask;
    int_srv = |avail;
    sel_oh  = '0;
    sel_cat = CATW'(INT_CAT0);
    // ascending scan: the highest channel wins
    for (int k = 0; k < NINT; k++) begin
      if (avail[k]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        sel_cat   = CATW'(INT_CAT0 + k);
      end
    end
    pend_nx = (pend_q | (int_rq & ~rq_prev))
            & EDGE_MASK;
    full    = sp == SPW'(SDEPTH);
    empty   = sp == '0;
    fault   = (call & ret) | (call & full)
            | (ret & empty);
    pop_i   = IW'(sp - SPW'(1));
    push    = cen & (st == RUN) & ~busy
            & call & ~fault;
  end

  // contents survive reset; only sp decides validity
  always_ff @(posedge clk) begin
    if (push) stk[IW'(sp)] <= addr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= entry(CATW'(RST_CAT));
      st      <= RUN;
      sp      <= '0;
      pend_q  <= '0;
      rq_prev <= '0;
      int_vec <= '0;
      err     <= 1'b0;
    end else if (cen && st != HALT) begin
      rq_prev <= int_rq;
      pend_q  <= pend_nx;
      unique case (st)
        RUN: if (!busy) begin
          if (fault) begin
            err <= 1'b1;
            st  <= HALT;
          end else if (ret) begin
            addr <= stk[pop_i];
            sp   <= sp - 1'b1;
          end else if (call) begin
            addr <= jmp_addr;
            sp   <= sp + 1'b1;
          end else if (jmp) begin
            addr <= jmp_addr;
          end else if (ni) begin
            if (int_srv) begin
              addr    <= entry(sel_cat);
              int_vec <= sel_oh;
              // servicing beats a coincident new edge
              pend_q  <= pend_nx & ~sel_oh;
            end else begin
              st <= FETCH;
            end
          end else begin
            addr <= addr + 1'b1;
          end
        end
        FETCH: if (!busy) st <= DISPATCH;
        DISPATCH: begin
          if (bad_cat) begin
            err <= 1'b1;
            st  <= HALT;
          end else begin
            addr    <= entry(cat);
            int_vec <= '0;
            st      <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_useq.sv
// Self-checking bench for jtkcpu_useq: directed test-plan steps
// followed by randomized traffic against a queue-based reference model.
module tb_jtkcpu_useq;

  localparam logic [2:0] EDGE = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       busy = 1'b0;
  logic       ni = 1'b0;
  logic       jmp = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [9:0] jmp_addr = '0;
  logic [5:0] cat = '0;
  logic       bad_cat = 1'b0;
  logic [2:0] int_rq = '0;
  logic [2:0] int_mask = '0;
  logic [9:0] addr;
  logic [2:0] int_vec;
  logic       int_srv;
  logic       err;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 run, 1 fetch, 2 dispatch, 3 halted
  logic [9:0] m_addr;
  int         m_mode;
  logic [9:0] m_stk[$];
  logic [2:0] m_pend, m_prev, m_vec;
  logic       m_err;

  jtkcpu_useq dut (
    .clk(clk), .rst(rst), .cen(cen), .busy(busy),
    .ni(ni), .jmp(jmp), .call(call), .ret(ret),
    .jmp_addr(jmp_addr), .cat(cat), .bad_cat(bad_cat),
    .int_rq(int_rq), .int_mask(int_mask),
    .addr(addr), .int_vec(int_vec),
    .int_srv(int_srv), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             name, got, exp);
    end
  endtask

  function automatic logic [2:0] m_avail();
    logic [2:0] p;
    p = (m_pend & EDGE) | (int_rq & ~EDGE);
    return p & ~int_mask;
  endfunction

  task automatic model_reset();
    m_addr = '0;
    m_mode = 0;
    m_stk.delete();
    m_pend = '0;
    m_prev = '0;
    m_vec  = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] av, np;
    int k;
    if (m_mode == 3 || !cen) return;
    av = m_avail();
    np = m_pend | (int_rq & ~m_prev & EDGE);
    m_prev = int_rq;
    case (m_mode)
      0: if (!busy) begin
        if ((call && ret) ||
            (call && m_stk.size() == 4) ||
            (ret && m_stk.size() == 0)) begin
          m_err = 1'b1;
          m_mode = 3;
        end else if (ret) begin
          m_addr = m_stk.pop_back();
        end else if (call) begin
          m_stk.push_back(m_addr + 10'd1);
          m_addr = jmp_addr;
        end else if (jmp) begin
          m_addr = jmp_addr;
        end else if (ni) begin
          if (av != 0) begin
            k = 2;
            while (!av[k]) k--;
            m_addr = 10'((1 + k) * 16);
            m_vec  = 3'(1 << k);
            np[k]  = 1'b0;
          end else begin
            m_mode = 1;
          end
        end else begin
          m_addr = m_addr + 10'd1;
        end
      end
      1: if (!busy) m_mode = 2;
      2: begin
        if (bad_cat) begin
          m_err = 1'b1;
          m_mode = 3;
        end else begin
          m_addr = {cat, 4'b0};
          m_vec  = '0;
          m_mode = 0;
        end
      end
      default: ;
    endcase
    m_pend = np;
  endtask

  // called at a negedge with inputs already driven
  task automatic cyc();
    #1;
    chk("int_srv", int_srv, (m_avail() != 0));
    @(posedge clk);
    model_step();
    #1;
    chk("addr", addr, m_addr);
    chk("int_vec", int_vec, m_vec);
    chk("err", err, m_err);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_addr", addr, m_addr);
    chk("rst_vec", int_vec, m_vec);
    chk("rst_err", err, m_err);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    repeat (3) cyc();
    chk("count3", addr, 10'h003);

    jmp = 1; jmp_addr = 10'h3ff; cyc();
    jmp = 0; cyc();
    chk("wrap", addr, 10'h000);

    jmp = 1; jmp_addr = 10'h005; cyc();
    jmp = 0; ni = 1; cat = 6'd9; cyc();
    chk("fetch_hold", addr, 10'h005);
    ni = 0; busy = 1; cyc(); cyc();
    busy = 0; cyc();
    chk("dispatch_hold", addr, 10'h005);
    cyc();
    chk("dispatch", addr, 10'h090);

    call = 1; jmp_addr = 10'h200; cyc();
    chk("call", addr, 10'h200);
    call = 0; ret = 1; cyc();
    chk("ret", addr, 10'h091);
    ret = 0;

    call = 1; repeat (5) cyc();
    call = 0;
    chk("overflow_err", err, 1'b1);
    repeat (2) cyc();
    chk("halt_addr", addr, 10'h200);

    do_reset();
    ret = 1; cyc();
    ret = 0;
    chk("underflow_err", err, 1'b1);
    do_reset();

    int_mask = 3'b100; int_rq = 3'b100; cyc();
    int_rq = 0; repeat (10) cyc();
    int_mask = 0; ni = 1; cyc();
    chk("edge_addr", addr, 10'h030);
    chk("edge_vec", int_vec, 3'b100);
    ni = 0; int_rq = 3'b100; cyc();
    ni = 1; cyc(); cyc();
    chk("no_retrig", addr, 10'h030);
    ni = 0; cat = 6'd9; cyc(); cyc();
    chk("vec_clr", int_vec, 3'b000);
    int_rq = 0;

    int_rq = 3'b011; ni = 1; cyc();
    chk("prio_addr", addr, 10'h020);
    chk("prio_vec", int_vec, 3'b010);
    ni = 0; int_rq = 0; cyc();
    ni = 1; cyc();
    ni = 0; cyc(); cyc();
    chk("lvl_vec_clr", int_vec, 3'b000);

    ni = 1; cyc();
    ni = 0; bad_cat = 1; cyc(); cyc();
    chk("bad_cat", err, 1'b1);
    cyc();
    bad_cat = 0;
    #2;
    do_reset();
    chk("async_addr", addr, 10'h000);

    cen = 0; repeat (2) cyc();
    cen = 1;

    for (int i = 0; i < 800; i++) begin
      if ((m_mode == 3 && $urandom_range(0, 3) == 0)
          || $urandom_range(0, 149) == 0)
        do_reset();
      cen      = ($urandom_range(0, 9) != 0);
      busy     = ($urandom_range(0, 4) == 0);
      ni       = ($urandom_range(0, 5) == 0);
      jmp      = ($urandom_range(0, 9) == 0);
      call     = ($urandom_range(0, 9) == 0);
      ret      = ($urandom_range(0, 9) == 0);
      bad_cat  = ($urandom_range(0, 19) == 0);
      jmp_addr = 10'($urandom);
      cat      = 6'($urandom);
      int_rq   = 3'($urandom);
      int_mask = 3'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
